// File: rtl/mod_pingpong_ctrl.sv
// Ping-pong symbol bank controller: zero-latency write steering, reads start one cycle after Rd_Start.
// Backpressure: Stall holds the mapper while the write bank is FULL/READING; dropped symbols set sticky Overflow.
module mod_pingpong_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int MAX_SYM = 1200
) (
    input  logic              CLK_PP,
    input  logic              RST_PP,
    input  logic              Sym_Valid,
    input  logic              Blk_Done,
    input  logic              Rd_Start,
    output logic              Wr_En,
    output logic              Wr_Bank,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic              Rd_En,
    output logic              Rd_Bank,
    output logic [ADDR_W-1:0] Rd_Addr,
    output logic              Rd_Last,
    output logic [ADDR_W-1:0] Rd_Len,
    output logic              Bank_Ready,
    output logic              Stall,
    output logic              Overflow
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_st_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_SYM - 1);

    bank_st_t          bank_st     [2];
    bank_st_t          bank_st_nxt [2];
    logic [ADDR_W-1:0] bank_len     [2];
    logic [ADDR_W-1:0] bank_len_nxt [2];

    logic              next_rd;
    logic              close_wr;
    logic              rd_go;
    logic              rd_release;
    logic [ADDR_W-1:0] close_len;
    logic [ADDR_W-1:0] rd_addr_inc;

    always_comb begin
        Stall       = (bank_st[Wr_Bank] == BANK_FULL) || (bank_st[Wr_Bank] == BANK_READING);
        Wr_En       = Sym_Valid && !Stall;
        // A write accepted in the closing cycle still counts toward the bank length.
        close_len   = Wr_En ? (Wr_Addr + ADDR_ONE) : Wr_Addr;
        close_wr    = (Wr_En && (Wr_Addr == ADDR_LAST)) ||
                      (Blk_Done && ((bank_st[Wr_Bank] == BANK_FILLING) || Wr_En));
        Bank_Ready  = (bank_st[next_rd] == BANK_FULL) && !Rd_En;
        rd_go       = Rd_Start && Bank_Ready;
        rd_release  = Rd_En && Rd_Last;
        rd_addr_inc = Rd_Addr + ADDR_ONE;
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_nxt[b]  = bank_st[b];
            bank_len_nxt[b] = bank_len[b];
            if (Wr_Bank == 1'(b)) begin
                if (close_wr) begin
                    bank_st_nxt[b]  = BANK_FULL;
                    bank_len_nxt[b] = close_len;
                end else if (Wr_En && (bank_st[b] == BANK_EMPTY)) begin
                    bank_st_nxt[b] = BANK_FILLING;
                end
            end
            if (rd_go && (next_rd == 1'(b))) begin
                bank_st_nxt[b] = BANK_READING;
            end
            if (rd_release && (Rd_Bank == 1'(b))) begin
                bank_st_nxt[b] = BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge CLK_PP) begin
        if (RST_PP) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= BANK_EMPTY;
                bank_len[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= bank_st_nxt[b];
                bank_len[b] <= bank_len_nxt[b];
            end
        end
    end

    always_ff @(posedge CLK_PP) begin
        if (RST_PP) begin
            Wr_Bank  <= 1'b0;
            Wr_Addr  <= '0;
            Overflow <= 1'b0;
        end else begin
            if (close_wr) begin
                Wr_Addr <= '0;
                Wr_Bank <= ~Wr_Bank;
            end else if (Wr_En) begin
                Wr_Addr <= Wr_Addr + ADDR_ONE;
            end
            if (Sym_Valid && Stall) begin
                Overflow <= 1'b1;
            end
        end
    end

    // Reader: one address per cycle; Rd_Last is precomputed so it lines up with the final Rd_En.
    always_ff @(posedge CLK_PP) begin
        if (RST_PP) begin
            next_rd <= 1'b0;
            Rd_En   <= 1'b0;
            Rd_Bank <= 1'b0;
            Rd_Addr <= '0;
            Rd_Last <= 1'b0;
            Rd_Len  <= '0;
        end else if (rd_go) begin
            next_rd <= ~next_rd;
            Rd_En   <= 1'b1;
            Rd_Bank <= next_rd;
            Rd_Addr <= '0;
            Rd_Len  <= bank_len[next_rd];
            Rd_Last <= (bank_len[next_rd] == ADDR_ONE);
        end else if (Rd_En) begin
            if (Rd_Last) begin
                Rd_En   <= 1'b0;
                Rd_Last <= 1'b0;
            end else begin
                Rd_Addr <= rd_addr_inc;
                Rd_Last <= (rd_addr_inc == (Rd_Len - ADDR_ONE));
            end
        end
    end

endmodule

// File: tb/tb_mod_pingpong_ctrl.sv
// Scoreboard bench for mod_pingpong_ctrl: expected read beats queued at Rd_Start, compared as Rd_En fires.
module tb_mod_pingpong_ctrl;

    localparam int ADDR_W  = 11;
    localparam int MAX_SYM = 1200;

    logic              CLK_PP = 1'b0;
    logic              RST_PP = 1'b1;
    logic              Sym_Valid = 1'b0;
    logic              Blk_Done = 1'b0;
    logic              Rd_Start = 1'b0;
    logic              Wr_En;
    logic              Wr_Bank;
    logic [ADDR_W-1:0] Wr_Addr;
    logic              Rd_En;
    logic              Rd_Bank;
    logic [ADDR_W-1:0] Rd_Addr;
    logic              Rd_Last;
    logic [ADDR_W-1:0] Rd_Len;
    logic              Bank_Ready;
    logic              Stall;
    logic              Overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int bank;
        int addr;
        int last;
        int len;
    } beat_t;

    beat_t sb[$];

    mod_pingpong_ctrl #(.ADDR_W(ADDR_W), .MAX_SYM(MAX_SYM)) dut (
        .CLK_PP     (CLK_PP),
        .RST_PP     (RST_PP),
        .Sym_Valid  (Sym_Valid),
        .Blk_Done   (Blk_Done),
        .Rd_Start   (Rd_Start),
        .Wr_En      (Wr_En),
        .Wr_Bank    (Wr_Bank),
        .Wr_Addr    (Wr_Addr),
        .Rd_En      (Rd_En),
        .Rd_Bank    (Rd_Bank),
        .Rd_Addr    (Rd_Addr),
        .Rd_Last    (Rd_Last),
        .Rd_Len     (Rd_Len),
        .Bank_Ready (Bank_Ready),
        .Stall      (Stall),
        .Overflow   (Overflow)
    );

    always #5 CLK_PP = ~CLK_PP;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_PP);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK_PP);
    endtask

    always @(negedge CLK_PP) begin
        if (!RST_PP && Rd_En) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected_beat", 1, 0);
            end else begin
                beat_t b;
                b = sb.pop_front();
                chk("rd_bank", int'(Rd_Bank), b.bank);
                chk("rd_addr", int'(Rd_Addr), b.addr);
                chk("rd_last", int'(Rd_Last), b.last);
                chk("rd_len",  int'(Rd_Len),  b.len);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_wr_bank", int'(Wr_Bank), 0);
        chk("rst_wr_addr", int'(Wr_Addr), 0);
        chk("rst_rd_en",   int'(Rd_En), 0);
        chk("rst_rd_bank", int'(Rd_Bank), 0);
        chk("rst_rd_addr", int'(Rd_Addr), 0);
        chk("rst_rd_last", int'(Rd_Last), 0);
        chk("rst_rd_len",  int'(Rd_Len), 0);
        chk("rst_ready",   int'(Bank_Ready), 0);
        chk("rst_stall",   int'(Stall), 0);
        chk("rst_ovf",     int'(Overflow), 0);
        chk("rst_wr_en",   int'(Wr_En), int'(Sym_Valid));
    endtask

    task automatic do_reset();
        Sym_Valid = 1'b0;
        Blk_Done  = 1'b0;
        Rd_Start  = 1'b0;
        RST_PP    = 1'b1;
        tick();
        tick();
        RST_PP = 1'b0;
        sb.delete();
    endtask

    task automatic write_block(input int n, input bit done, input int bank);
        for (int i = 0; i < n; i++) begin
            Sym_Valid = 1'b1;
            Blk_Done  = done && (i == n - 1);
            mid();
            chk("wr_en",   int'(Wr_En), 1);
            chk("wr_addr", int'(Wr_Addr), i);
            chk("wr_bank", int'(Wr_Bank), bank);
            tick();
        end
        Sym_Valid = 1'b0;
        Blk_Done  = 1'b0;
    endtask

    task automatic push_beats(input int bank, input int len);
        for (int a = 0; a < len; a++) begin
            beat_t b;
            b.bank = bank;
            b.addr = a;
            b.last = (a == len - 1) ? 1 : 0;
            b.len  = len;
            sb.push_back(b);
        end
    endtask

    task automatic start_read(input int bank, input int len);
        Rd_Start = 1'b1;
        push_beats(bank, len);
        mid();
        chk("ready_at_start", int'(Bank_Ready), 1);
        tick();
        Rd_Start = 1'b0;
    endtask

    task automatic wait_rd_done();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !Rd_En) break;
            tick();
        end
        mid();
        chk("rd_drained", sb.size(), 0);
        chk("rd_idle", int'(Rd_En), 0);
        tick();
    endtask

    initial begin
        do_reset();
        mid();
        check_reset_vals();
        tick();

        // Blk_Done on an empty bank is ignored
        Blk_Done = 1'b1;
        tick();
        Blk_Done = 1'b0;
        mid();
        chk("empty_done_ready", int'(Bank_Ready), 0);
        chk("empty_done_bank",  int'(Wr_Bank), 0);
        chk("empty_done_stall", int'(Stall), 0);
        tick();

        // 5 symbols closed by Blk_Done on the last one
        write_block(5, 1'b1, 0);
        mid();
        chk("b5_wr_bank", int'(Wr_Bank), 1);
        chk("b5_wr_addr", int'(Wr_Addr), 0);
        chk("b5_ready",   int'(Bank_Ready), 1);
        chk("b5_stall",   int'(Stall), 0);
        tick();
        start_read(0, 5);
        wait_rd_done();

        // Both banks full, stall and sticky overflow, reads in fill order
        do_reset();
        write_block(3, 1'b1, 0);
        write_block(4, 1'b1, 1);
        Sym_Valid = 1'b1;
        mid();
        chk("pp_stall", int'(Stall), 1);
        chk("pp_wr_en", int'(Wr_En), 0);
        tick();
        mid();
        chk("pp_ovf", int'(Overflow), 1);
        chk("pp_wr_addr_held", int'(Wr_Addr), 0);
        Sym_Valid = 1'b0;
        tick();
        mid();
        chk("pp_ovf_sticky", int'(Overflow), 1);
        tick();
        start_read(0, 3);
        tick();
        tick();
        mid();
        chk("pp_stall_on_last", int'(Stall), 1);
        chk("pp_last_cycle", int'(Rd_Last), 1);
        tick();
        mid();
        chk("pp_stall_released", int'(Stall), 0);
        chk("pp_ready_bank1", int'(Bank_Ready), 1);
        tick();
        start_read(1, 4);
        wait_rd_done();
        chk("pp_ovf_still", int'(Overflow), 1);

        // Read of 7 with ignored Rd_Start during and right after the read
        do_reset();
        write_block(7, 1'b1, 0);
        start_read(0, 7);
        mid();
        chk("r7_ready_busy", int'(Bank_Ready), 0);
        tick();
        tick();
        Rd_Start = 1'b1;
        tick();
        Rd_Start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        mid();
        chk("r7_idle_t8", int'(Rd_En), 0);
        chk("r7_ready_t8", int'(Bank_Ready), 0);
        Rd_Start = 1'b1;
        tick();
        Rd_Start = 1'b0;
        mid();
        chk("r7_idle_t9", int'(Rd_En), 0);
        tick();
        tick();
        chk("r7_no_beats", sb.size(), 0);

        // Close of bank 1 in the same cycle bank 0 is released
        do_reset();
        write_block(2, 1'b1, 0);
        Rd_Start  = 1'b1;
        Sym_Valid = 1'b1;
        push_beats(0, 2);
        mid();
        chk("sim_wr_bank", int'(Wr_Bank), 1);
        chk("sim_wr_a0", int'(Wr_Addr), 0);
        tick();
        Rd_Start = 1'b0;
        mid();
        chk("sim_wr_a1", int'(Wr_Addr), 1);
        tick();
        Blk_Done = 1'b1;
        mid();
        chk("sim_wr_a2", int'(Wr_Addr), 2);
        chk("sim_rd_last", int'(Rd_Last), 1);
        tick();
        Sym_Valid = 1'b0;
        Blk_Done  = 1'b0;
        mid();
        chk("sim_stall", int'(Stall), 0);
        chk("sim_wr_bank_back", int'(Wr_Bank), 0);
        chk("sim_ready", int'(Bank_Ready), 1);
        tick();
        start_read(1, 3);
        wait_rd_done();

        // Auto-close at MAX_SYM
        do_reset();
        write_block(MAX_SYM, 1'b0, 0);
        mid();
        chk("auto_wr_bank", int'(Wr_Bank), 1);
        chk("auto_wr_addr", int'(Wr_Addr), 0);
        chk("auto_ready", int'(Bank_Ready), 1);
        tick();
        start_read(0, MAX_SYM);
        wait_rd_done();

        // Reset in the middle of a read
        do_reset();
        write_block(5, 1'b1, 0);
        start_read(0, 5);
        for (int i = 0; i < 10; i++) begin
            if (Rd_Addr == ADDR_W'(2)) break;
            tick();
        end
        chk("mr_reached_addr2", int'(Rd_Addr), 2);
        RST_PP = 1'b1;
        tick();
        RST_PP = 1'b0;
        sb.delete();
        mid();
        check_reset_vals();
        tick();
        write_block(2, 1'b1, 0);
        mid();
        chk("mr_ready", int'(Bank_Ready), 1);
        tick();
        start_read(0, 2);
        wait_rd_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
